// File: rtl/single_process_array_pkg.sv
// Shared types, sizes and operand-index helpers for the single-MAC 2x2 convolution block.
package single_process_array_pkg;

   localparam int N_A   = 4;
   localparam int N_K   = 3;
   localparam int N_OUT = 2;
   localparam int TAPS  = 9;
   localparam int STEPS = 36;
   localparam int DW    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef logic [5:0] step_t;

   function automatic logic [3:0] tap_of(input step_t k);
      return 4'(int'(k) % TAPS);
   endfunction

   function automatic logic [1:0] out_of(input step_t k);
      return 2'(int'(k) / TAPS);
   endfunction

   // Flat row-major A index of the window element used at step k.
   function automatic logic [3:0] a_index(input step_t k);
      int o;
      int t;
      int row;
      int col;
      o   = int'(k) / TAPS;
      t   = int'(k) % TAPS;
      row = (o / N_OUT) + (t / N_K);
      col = (o % N_OUT) + (t % N_K);
      return 4'(row * N_A + col);
   endfunction

   // The flipped kernel index collapses to (TAPS-1) - tap.
   function automatic logic [3:0] b_index(input step_t k);
      return 4'((TAPS - 1) - (int'(k) % TAPS));
   endfunction

endpackage

// File: rtl/single_process_array_mac8.sv
// 8x8 multiply with 8-bit wrapping accumulate; sum shows acc + a*b for the current operands.
module single_process_array_mac8
   import single_process_array_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] sum
);

   logic [DW-1:0] acc_q;
   logic [DW-1:0] acc_d;
   logic [DW-1:0] prod;

   // clr wins over en so the final tap of a sum can be read out while the accumulator restarts.
   always_comb begin
      prod  = a * b;
      sum   = acc_q + prod;
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = sum;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/single_process_array.sv
// 2x2 valid convolution of a 4x4 matrix with a flipped 3x3 kernel, one MAC per cycle over 36 steps.
module single_process_array
   import single_process_array_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          active_single,
   input  logic [DW-1:0] a11, a12, a13, a14,
   input  logic [DW-1:0] a21, a22, a23, a24,
   input  logic [DW-1:0] a31, a32, a33, a34,
   input  logic [DW-1:0] a41, a42, a43, a44,
   input  logic [DW-1:0] b11, b12, b13,
   input  logic [DW-1:0] b21, b22, b23,
   input  logic [DW-1:0] b31, b32, b33,
   output logic          done_single,
   output logic [DW-1:0] c11,
   output logic [DW-1:0] c12,
   output logic [DW-1:0] c21,
   output logic [DW-1:0] c22
);

   // Handshake: a run starts when active_single is seen high in IDLE; done_single stays high
   // until active_single is seen low, so a held request yields exactly one run.

   state_e        state_q, state_d;
   step_t         k_q, k_d;
   logic          done_q, done_d;
   logic [DW-1:0] a_q [N_A*N_A];
   logic [DW-1:0] a_d [N_A*N_A];
   logic [DW-1:0] b_q [TAPS];
   logic [DW-1:0] b_d [TAPS];
   logic [DW-1:0] c_q [N_OUT*N_OUT];
   logic [DW-1:0] c_d [N_OUT*N_OUT];
   logic [DW-1:0] a_in [N_A*N_A];
   logic [DW-1:0] b_in [TAPS];

   logic          mac_clr;
   logic          mac_en;
   logic [DW-1:0] mac_a;
   logic [DW-1:0] mac_b;
   logic [DW-1:0] mac_sum;

   assign a_in = '{a11, a12, a13, a14, a21, a22, a23, a24,
                   a31, a32, a33, a34, a41, a42, a43, a44};
   assign b_in = '{b11, b12, b13, b21, b22, b23, b31, b32, b33};

   assign mac_a = a_q[a_index(k_q)];
   assign mac_b = b_q[b_index(k_q)];

   single_process_array_mac8 u_mac8 (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (mac_a),
      .b   (mac_b),
      .sum (mac_sum)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      done_d  = done_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (active_single) begin
               state_d = RUN;
               k_d     = '0;
               a_d     = a_in;
               b_d     = b_in;
               mac_clr = 1'b1;
            end
         end
         RUN: begin
            mac_en = 1'b1;
            if (tap_of(k_q) == 4'(TAPS - 1)) begin
               c_d[out_of(k_q)] = mac_sum;
               mac_clr          = 1'b1;
            end
            if (k_q == step_t'(STEPS - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               k_d     = '0;
            end else begin
               k_d = k_q + 6'd1;
            end
         end
         DONE: begin
            if (!active_single) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         done_q  <= 1'b0;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         c_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

   assign done_single = done_q;
   assign c11         = c_q[0];
   assign c12         = c_q[1];
   assign c21         = c_q[2];
   assign c22         = c_q[3];

endmodule

// File: tb/tb_single_process_array.sv
// Directed and randomized runs of single_process_array checked against a convolution model.
module tb_single_process_array;

   logic       clk;
   logic       rst;
   logic       active_single;
   logic [7:0] a_v [16];
   logic [7:0] b_v [9];
   logic       done_single;
   logic [7:0] c11, c12, c21, c22;

   int checks;
   int errors;
   logic [7:0] exp_q[$];

   single_process_array dut (
      .clk           (clk),
      .rst           (rst),
      .active_single (active_single),
      .a11 (a_v[0]),  .a12 (a_v[1]),  .a13 (a_v[2]),  .a14 (a_v[3]),
      .a21 (a_v[4]),  .a22 (a_v[5]),  .a23 (a_v[6]),  .a24 (a_v[7]),
      .a31 (a_v[8]),  .a32 (a_v[9]),  .a33 (a_v[10]), .a34 (a_v[11]),
      .a41 (a_v[12]), .a42 (a_v[13]), .a43 (a_v[14]), .a44 (a_v[15]),
      .b11 (b_v[0]),  .b12 (b_v[1]),  .b13 (b_v[2]),
      .b21 (b_v[3]),  .b22 (b_v[4]),  .b23 (b_v[5]),
      .b31 (b_v[6]),  .b32 (b_v[7]),  .b33 (b_v[8]),
      .done_single   (done_single),
      .c11 (c11), .c12 (c12), .c21 (c21), .c22 (c22)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // reference model: cRC = sum a(R+i-1,C+j-1) * b(4-i,4-j), mod 256
   function automatic logic [7:0] conv(input int r, input int c);
      int s;
      s = 0;
      for (int i = 1; i <= 3; i++)
         for (int j = 1; j <= 3; j++)
            s += int'(a_v[(r + i - 2) * 4 + (c + j - 2)]) * int'(b_v[(3 - i) * 3 + (3 - j)]);
      return 8'(s % 256);
   endfunction

   task automatic push_expected();
      exp_q.delete();
      exp_q.push_back(conv(1, 1));
      exp_q.push_back(conv(1, 2));
      exp_q.push_back(conv(2, 1));
      exp_q.push_back(conv(2, 2));
   endtask

   // driver: start a run from IDLE and follow it to done_single
   task automatic do_run(input bit scramble);
      int cyc;
      push_expected();
      active_single = 1'b1;
      tick();                                  // edge S
      cyc = 0;
      while (cyc < 100 && !done_single) begin
         tick();
         cyc++;
         if (scramble && cyc == 5) begin
            for (int i = 0; i < 16; i++) a_v[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 9; i++)  b_v[i] = 8'($urandom_range(0, 255));
         end
         if (cyc == 9)  check("c11_at_s9",  c11, exp_q[0]);
         if (cyc == 18) check("c12_at_s18", c12, exp_q[1]);
         if (cyc == 27) check("c21_at_s27", c21, exp_q[2]);
      end
      check("done_rise", {7'd0, done_single}, 8'd1);
      check("latency", 8'(cyc), 8'd36);
      check("c11", c11, exp_q.pop_front());
      check("c12", c12, exp_q.pop_front());
      check("c21", c21, exp_q.pop_front());
      check("c22", c22, exp_q.pop_front());
   endtask

   task automatic end_run();
      active_single = 1'b0;
      tick();
      check("done_fall", {7'd0, done_single}, 8'd0);
   endtask

   task automatic set_seq_ab();
      for (int i = 0; i < 16; i++) a_v[i] = 8'(i + 1);
      for (int i = 0; i < 9; i++)  b_v[i] = 8'(i + 1);
   endtask

   initial begin
      logic [7:0] hold_c [4];
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      active_single = 1'b0;
      for (int i = 0; i < 16; i++) a_v[i] = '0;
      for (int i = 0; i < 9; i++)  b_v[i] = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rst_done", {7'd0, done_single}, 8'd0);
      check("rst_c11", c11, 8'd0);
      check("rst_c12", c12, 8'd0);
      check("rst_c21", c21, 8'd0);
      check("rst_c22", c22, 8'd0);

      // sequential A and B, known values 192/237/116/161
      set_seq_ab();
      do_run(1'b0);
      check("seq_c11_known", c11, 8'd192);
      check("seq_c22_known", c22, 8'd161);
      hold_c = '{c11, c12, c21, c22};
      repeat (40) tick();
      check("held_done", {7'd0, done_single}, 8'd1);
      check("held_c11", c11, hold_c[0]);
      check("held_c22", c22, hold_c[3]);
      end_run();
      check("idle_hold_c12", c12, hold_c[1]);

      // kernel flip: only b11 set
      for (int i = 0; i < 9; i++) b_v[i] = '0;
      b_v[0] = 8'd1;
      do_run(1'b0);
      check("flip_c11_known", c11, 8'd11);
      end_run();

      // only b22 set
      b_v[0] = 8'd0;
      b_v[4] = 8'd1;
      do_run(1'b0);
      check("center_c21_known", c21, 8'd10);
      end_run();

      // wrap-around
      for (int i = 0; i < 16; i++) a_v[i] = 8'd255;
      for (int i = 0; i < 9; i++)  b_v[i] = 8'd255;
      do_run(1'b0);
      check("wrap_c12_known", c12, 8'd9);
      end_run();

      for (int i = 0; i < 9; i++) b_v[i] = 8'd0;
      do_run(1'b0);
      end_run();

      // reset at step 20 of a run
      set_seq_ab();
      active_single = 1'b1;
      tick();
      repeat (20) tick();
      rst = 1'b0;
      tick();
      check("midrst_done", {7'd0, done_single}, 8'd0);
      check("midrst_c11", c11, 8'd0);
      check("midrst_c12", c12, 8'd0);
      check("midrst_c21", c21, 8'd0);
      check("midrst_c22", c22, 8'd0);
      rst           = 1'b1;
      active_single = 1'b0;
      tick();
      do_run(1'b0);

      // held high after DONE, then a one-cycle drop with a new kernel
      repeat (10) tick();
      check("no_rerun_done", {7'd0, done_single}, 8'd1);
      end_run();
      for (int i = 0; i < 9; i++) b_v[i] = 8'(9 - i);
      do_run(1'b0);
      end_run();

      // randomized runs with inputs scrambled after the start edge
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) a_v[i] = 8'($urandom_range(0, 255));
         for (int i = 0; i < 9; i++)  b_v[i] = 8'($urandom_range(0, 255));
         do_run(1'b1);
         repeat ($urandom_range(0, 3)) tick();
         end_run();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
